// File: rtl/vram_pkg.sv
// Shared types for the video RAM arbiter: drain FSM states, default widths
// and the posted-write entry layout.
package vram_pkg;

    localparam int VRAM_ADDR_W = 19;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } drain_state_e;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [VRAM_DATA_W-1:0] data;
    } wr_entry_t;

    // Occupancy counter must reach DEPTH itself, hence one bit over the pointer width.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Posted-write circular buffer. Besides push/pop it offers an address lookup
// that returns the newest queued data for that address (read forwarding).
module vram_wr_fifo
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      push_i,
    input  logic [ADDR_W-1:0]         push_addr_i,
    input  logic [DATA_W-1:0]         push_data_i,
    input  logic                      pop_i,
    output logic [ADDR_W-1:0]         head_addr_o,
    output logic [DATA_W-1:0]         head_data_o,
    output logic                      full_o,
    output logic [cnt_w(DEPTH)-1:0]   count_o,
    input  logic [ADDR_W-1:0]         lookup_addr_i,
    output logic                      hit_o,
    output logic [DATA_W-1:0]         hit_data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, slot;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o      = (count_q == CW'(DEPTH));
    assign count_o     = count_q;
    assign push_ok     = push_i && !full_o;
    assign pop_ok      = pop_i && (count_q != '0);
    assign head_addr_o = addr_mem[rd_ptr_q];
    assign head_data_o = data_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            addr_mem[wr_ptr_q] <= push_addr_i;
            data_mem[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Walk oldest to newest so the last hit (newest write) wins.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        slot       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_mem[slot] == lookup_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = data_mem[slot];
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Shares one async SRAM between the ISA port (posted writes, forwarded reads)
// and the CRTC pixel fetch port.
//
// state  | meaning
// IDLE   | SRAM free for pixel fetch / ISA read
// SETUP  | head address and data driven, WE high
// STROBE | WE low, entry popped on exit
// HOLD   | WE high, address and data held for SRAM hold time
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W   = VRAM_ADDR_W,
    parameter int DATA_W   = VRAM_DATA_W,
    parameter int WR_DEPTH = 4,
    parameter int DIN_DLY  = 2,
    parameter int SNOW_EN  = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] isa_addr_i,
    input  logic [DATA_W-1:0] isa_din_i,
    output logic [DATA_W-1:0] isa_dout_o,
    input  logic              isa_read_i,
    input  logic              isa_write_i,
    output logic              wr_full_o,
    output logic              wr_overflow_o,
    input  logic [ADDR_W-1:0] pixel_addr_i,
    input  logic              pixel_read_i,
    output logic [DATA_W-1:0] pixel_data_o,
    output logic [ADDR_W-1:0] ram_a_o,
    input  logic [DATA_W-1:0] ram_din_i,
    output logic [DATA_W-1:0] ram_dout_o,
    output logic              ram_dout_en_o,
    output logic              ram_ce_l_o,
    output logic              ram_oe_l_o,
    output logic              ram_we_l_o
);

    localparam int          CW       = cnt_w(WR_DEPTH);
    localparam bit          SNOW     = (SNOW_EN != 0);
    localparam logic [2:0]  CAP_LOAD = 3'(DIN_DLY - 1);

    drain_state_e      state_q, state_d;
    logic              wr_prev_q, cap_busy_q, cap_busy_d, cap_push, wr_rise;
    logic [2:0]        cap_cnt_q, cap_cnt_d;
    logic [ADDR_W-1:0] cap_addr_q, cap_addr_d, drn_addr_q, drn_addr_d, head_addr;
    logic [DATA_W-1:0] drn_data_q, drn_data_d, head_data, hit_data;
    logic [DATA_W-1:0] pixel_q, pixel_d;
    logic              ovf_q, ovf_d;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty, fifo_pop, hit, drive_en, we_act, permit;

    vram_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (WR_DEPTH)
    ) u_fifo (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .push_i        (cap_push),
        .push_addr_i   (cap_addr_q),
        .push_data_i   (isa_din_i),
        .pop_i         (fifo_pop),
        .head_addr_o   (head_addr),
        .head_data_o   (head_data),
        .full_o        (fifo_full),
        .count_o       (fifo_count),
        .lookup_addr_i (isa_addr_i),
        .hit_o         (hit),
        .hit_data_o    (hit_data)
    );

    assign fifo_empty = (fifo_count == '0);
    assign wr_rise    = isa_write_i && !wr_prev_q;

    // Data is pushed the cycle it is captured, so the FIFO lookup already
    // covers every write whose data is known.
    always_comb begin
        cap_busy_d = cap_busy_q;
        cap_cnt_d  = cap_cnt_q;
        cap_addr_d = cap_addr_q;
        cap_push   = 1'b0;
        if (wr_rise) begin
            cap_busy_d = 1'b1;
            cap_cnt_d  = CAP_LOAD;
            cap_addr_d = isa_addr_i;
        end else if (cap_busy_q) begin
            if (cap_cnt_q == 3'd0) begin
                cap_push   = 1'b1;
                cap_busy_d = 1'b0;
            end else begin
                cap_cnt_d = cap_cnt_q - 3'd1;
            end
        end
    end

    assign ovf_d  = ovf_q || (cap_push && fifo_full);
    assign permit = SNOW || !pixel_read_i || fifo_full;

    always_comb begin
        state_d    = state_q;
        drn_addr_d = drn_addr_q;
        drn_data_d = drn_data_q;
        fifo_pop   = 1'b0;
        drive_en   = 1'b0;
        we_act     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !isa_read_i && permit) begin
                    state_d    = ST_SETUP;
                    drn_addr_d = head_addr;
                    drn_data_d = head_data;
                end
            end
            ST_SETUP: begin
                drive_en = !isa_read_i;
                state_d  = isa_read_i ? ST_IDLE : ST_STROBE;
            end
            ST_STROBE: begin
                drive_en = !isa_read_i;
                if (isa_read_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d  = ST_HOLD;
                    we_act   = 1'b1;
                    fifo_pop = 1'b1;
                end
            end
            ST_HOLD: begin
                drive_en = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pixel_d = (isa_read_i || state_q != ST_IDLE) ? '1 : ram_din_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            wr_prev_q  <= 1'b0;
            cap_busy_q <= 1'b0;
            cap_cnt_q  <= '0;
            cap_addr_q <= '0;
            drn_addr_q <= '0;
            drn_data_q <= '0;
            pixel_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_prev_q  <= isa_write_i;
            cap_busy_q <= cap_busy_d;
            cap_cnt_q  <= cap_cnt_d;
            cap_addr_q <= cap_addr_d;
            drn_addr_q <= drn_addr_d;
            drn_data_q <= drn_data_d;
            pixel_q    <= pixel_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ram_a_o       = isa_read_i ? isa_addr_i :
                           (state_q != ST_IDLE) ? drn_addr_q : pixel_addr_i;
    assign ram_dout_o    = drn_data_q;
    assign ram_dout_en_o = drive_en;
    assign ram_oe_l_o    = drive_en;
    assign ram_we_l_o    = !we_act;
    assign ram_ce_l_o    = 1'b0;
    assign isa_dout_o    = hit ? hit_data : ram_din_i;
    assign pixel_data_o  = pixel_q;
    assign wr_full_o     = fifo_full;
    assign wr_overflow_o = ovf_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: instance 0 runs with snow enabled, instance 1 without.
// Each SRAM write strobe is checked in order against expected posted writes.
module tb_vram_arbiter;

    localparam int AW = 19;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n;

    logic [AW-1:0] isa_addr [2];
    logic [AW-1:0] pixel_addr [2];
    logic [AW-1:0] ram_a [2];
    logic [DW-1:0] isa_din [2];
    logic [DW-1:0] isa_dout [2];
    logic [DW-1:0] pixel_data [2];
    logic [DW-1:0] ram_din [2];
    logic [DW-1:0] ram_dout [2];
    logic          isa_read [2];
    logic          isa_write [2];
    logic          pixel_read [2];
    logic          wr_full [2];
    logic          wr_overflow [2];
    logic          ram_dout_en [2];
    logic          ram_ce_l [2];
    logic          ram_oe_l [2];
    logic          ram_we_l [2];

    logic [DW-1:0] mem [2][1024];
    bit            vld [2][1024];

    logic [AW+DW-1:0] q0[$];
    logic [AW+DW-1:0] q1[$];
    logic [AW+DW-1:0] e_mon;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        vram_arbiter #(
            .ADDR_W   (AW),
            .DATA_W   (DW),
            .WR_DEPTH (4),
            .DIN_DLY  (2),
            .SNOW_EN  (g == 0 ? 1 : 0)
        ) u_dut (
            .clk_i         (clk),
            .rst_n_i       (rst_n),
            .isa_addr_i    (isa_addr[g]),
            .isa_din_i     (isa_din[g]),
            .isa_dout_o    (isa_dout[g]),
            .isa_read_i    (isa_read[g]),
            .isa_write_i   (isa_write[g]),
            .wr_full_o     (wr_full[g]),
            .wr_overflow_o (wr_overflow[g]),
            .pixel_addr_i  (pixel_addr[g]),
            .pixel_read_i  (pixel_read[g]),
            .pixel_data_o  (pixel_data[g]),
            .ram_a_o       (ram_a[g]),
            .ram_din_i     (ram_din[g]),
            .ram_dout_o    (ram_dout[g]),
            .ram_dout_en_o (ram_dout_en[g]),
            .ram_ce_l_o    (ram_ce_l[g]),
            .ram_oe_l_o    (ram_oe_l[g]),
            .ram_we_l_o    (ram_we_l[g])
        );
        // Unwritten locations read back as a fixed pattern of their address.
        assign ram_din[g] = vld[g][ram_a[g][9:0]] ? mem[g][ram_a[g][9:0]]
                                                  : (ram_a[g][7:0] ^ 8'hC3);
    end

    function automatic logic [7:0] rd(input int d, input logic [AW-1:0] a);
        logic [9:0] idx;
        idx = a[9:0];
        return vld[d][idx] ? mem[d][idx] : (idx[7:0] ^ 8'hC3);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int d, input logic [AW-1:0] a, input logic [DW-1:0] v);
        if (d == 0) q0.push_back({a, v});
        else        q1.push_back({a, v});
    endtask

    // Monitor: every SRAM write strobe is matched against the oldest expected write.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n === 1'b1 && ram_we_l[d] === 1'b0) begin
                mem[d][ram_a[d][9:0]] = ram_dout[d];
                vld[d][ram_a[d][9:0]] = 1'b1;
                if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb%0d_unexpected_write: got addr 0x%0h data 0x%0h expected none",
                             d, ram_a[d], ram_dout[d]);
                end else begin
                    if (d == 0) e_mon = q0.pop_front();
                    else        e_mon = q1.pop_front();
                    chk($sformatf("sb%0d_addr", d), 32'(ram_a[d]), 32'(e_mon[AW+DW-1:DW]));
                    chk($sformatf("sb%0d_data", d), 32'(ram_dout[d]), 32'(e_mon[DW-1:0]));
                    chk($sformatf("sb%0d_drive", d), 32'(ram_dout_en[d]), 32'd1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int d, input logic [AW-1:0] a, input logic [DW-1:0] v,
                            input bit expect_drain);
        if (expect_drain) push_exp(d, a, v);
        isa_write[d] = 1'b1;
        isa_addr[d]  = a;
        isa_din[d]   = v;
        step();
        isa_write[d] = 1'b0;
        step();
        step();
    endtask

    task automatic wait_we_low(input int d, input string nm);
        int k;
        k = 0;
        while (ram_we_l[d] !== 1'b0 && k < 20) begin
            step();
            k++;
        end
        chk(nm, 32'(ram_we_l[d]), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            isa_addr[d]  = '0;
            isa_din[d]   = '0;
            isa_read[d]  = 1'b0;
            isa_write[d] = 1'b0;
        end
        pixel_addr[0] = 19'h00005;
        pixel_addr[1] = 19'h00010;
        pixel_read[0] = 1'b0;
        pixel_read[1] = 1'b1;

        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d_pix", d),  32'(pixel_data[d]),  32'h0);
            chk($sformatf("rst%0d_we", d),   32'(ram_we_l[d]),    32'h1);
            chk($sformatf("rst%0d_den", d),  32'(ram_dout_en[d]), 32'h0);
            chk($sformatf("rst%0d_oe", d),   32'(ram_oe_l[d]),    32'h0);
            chk($sformatf("rst%0d_ce", d),   32'(ram_ce_l[d]),    32'h0);
            chk($sformatf("rst%0d_ovf", d),  32'(wr_overflow[d]), 32'h0);
            chk($sformatf("rst%0d_full", d), 32'(wr_full[d]),     32'h0);
        end
        #20;
        rst_n = 1'b1;
        step();
        step();

        // Single write, snow mode: 3-cycle drain and three all-ones pixels.
        do_write(0, 19'h00100, 8'h5A, 1'b1);
        chk("t1_pre_setup_den", 32'(ram_dout_en[0]), 32'h0);
        step();
        chk("t1_pix_pre",     32'(pixel_data[0]),  32'hC6);
        chk("t1_setup_den",   32'(ram_dout_en[0]), 32'h1);
        chk("t1_setup_oe",    32'(ram_oe_l[0]),    32'h1);
        chk("t1_setup_we",    32'(ram_we_l[0]),    32'h1);
        chk("t1_setup_addr",  32'(ram_a[0]),       32'h00100);
        step();
        chk("t1_strobe_we",   32'(ram_we_l[0]),    32'h0);
        chk("t1_strobe_dout", 32'(ram_dout[0]),    32'h5A);
        chk("t1_pix_ff1",     32'(pixel_data[0]),  32'hFF);
        step();
        chk("t1_hold_we",     32'(ram_we_l[0]),    32'h1);
        chk("t1_hold_den",    32'(ram_dout_en[0]), 32'h1);
        chk("t1_hold_addr",   32'(ram_a[0]),       32'h00100);
        chk("t1_pix_ff2",     32'(pixel_data[0]),  32'hFF);
        step();
        chk("t1_idle_den",    32'(ram_dout_en[0]), 32'h0);
        chk("t1_pix_ff3",     32'(pixel_data[0]),  32'hFF);
        step();
        chk("t1_pix_post",    32'(pixel_data[0]),  32'hC6);
        chk("t1_mem",         32'(rd(0, 19'h00100)), 32'h5A);

        // Second edge one cycle after the first: only the second write survives.
        isa_write[0] = 1'b1; isa_addr[0] = 19'h00300; isa_din[0] = 8'h11;
        step();
        isa_write[0] = 1'b0;
        step();
        push_exp(0, 19'h00301, 8'h22);
        isa_write[0] = 1'b1; isa_addr[0] = 19'h00301; isa_din[0] = 8'h22;
        step();
        isa_write[0] = 1'b0;
        step();
        step();
        repeat (8) step();
        chk("t6_old_untouched", 32'(rd(0, 19'h00300)), 32'hC3);
        chk("t6_new_written",   32'(rd(0, 19'h00301)), 32'h22);

        // Read-after-write forwarding while isa_read blocks the drain.
        push_exp(0, 19'h00200, 8'h33);
        isa_write[0] = 1'b1; isa_addr[0] = 19'h00200; isa_din[0] = 8'h33;
        step();
        isa_write[0] = 1'b0;
        isa_read[0]  = 1'b1;
        #1;
        chk("fwd_pre_sram", 32'(isa_dout[0]), 32'hC3);
        step();
        step();
        chk("fwd_hit",      32'(isa_dout[0]),   32'h33);
        chk("fwd_pix_ff",   32'(pixel_data[0]), 32'hFF);
        do_write(0, 19'h00200, 8'h44, 1'b1);
        chk("fwd_newest",   32'(isa_dout[0]),   32'h44);
        chk("fwd_no_drain", 32'(ram_dout_en[0]), 32'h0);
        chk("fwd_read_addr", 32'(ram_a[0]),     32'h00200);
        isa_read[0] = 1'b0;
        repeat (12) step();
        isa_read[0] = 1'b1;
        #1;
        chk("fwd_sram_after", 32'(isa_dout[0]), 32'h44);
        isa_read[0] = 1'b0;
        step();

        // isa_read during STROBE aborts combinationally; entry is retried.
        do_write(0, 19'h00180, 8'h77, 1'b1);
        wait_we_low(0, "abort_reach_strobe");
        isa_read[0] = 1'b1;
        isa_addr[0] = 19'h00040;
        #1;
        chk("abort_we",   32'(ram_we_l[0]),    32'h1);
        chk("abort_den",  32'(ram_dout_en[0]), 32'h0);
        chk("abort_addr", 32'(ram_a[0]),       32'h00040);
        chk("abort_dout", 32'(isa_dout[0]),    32'h83);
        step();
        step();
        chk("abort_we_held", 32'(ram_we_l[0]), 32'h1);
        isa_read[0] = 1'b0;
        repeat (8) step();
        chk("abort_retry_mem", 32'(rd(0, 19'h00180)), 32'h77);

        // No-snow instance with pixel fetch active: fill, forced drain, overflow.
        chk("ns_pix_idle", 32'(pixel_data[1]), 32'hD3);
        do_write(1, 19'h00080, 8'hA0, 1'b1);
        do_write(1, 19'h00081, 8'hA1, 1'b1);
        do_write(1, 19'h00082, 8'hA2, 1'b1);
        repeat (3) step();
        chk("ns_no_drain",  32'(ram_dout_en[1]), 32'h0);
        chk("ns_not_full",  32'(wr_full[1]),     32'h0);
        chk("ns_pix_plain", 32'(pixel_data[1]),  32'hD3);
        do_write(1, 19'h00083, 8'hA3, 1'b1);
        chk("ns_full",      32'(wr_full[1]),     32'h1);
        chk("ns_ovf_clear", 32'(wr_overflow[1]), 32'h0);
        do_write(1, 19'h00084, 8'hA4, 1'b0);
        chk("ns_ovf_set",   32'(wr_overflow[1]), 32'h1);
        chk("ns_pix_forced", 32'(pixel_data[1]), 32'hFF);
        chk("ns_after_pop", 32'(wr_full[1]),     32'h0);
        repeat (4) step();
        chk("ns_stall_den", 32'(ram_dout_en[1]), 32'h0);
        chk("ns_stall_pix", 32'(pixel_data[1]),  32'hD3);
        pixel_read[1] = 1'b0;
        repeat (16) step();
        chk("ns_sb_empty",   32'(q1.size()),             32'h0);
        chk("ns_dropped",    32'(rd(1, 19'h00084)),      32'h47);
        chk("ns_last_mem",   32'(rd(1, 19'h00083)),      32'hA3);
        chk("ns_ovf_sticky", 32'(wr_overflow[1]),        32'h1);
        chk("sb0_empty",     32'(q0.size()),             32'h0);
        chk("snow_ovf_clear", 32'(wr_overflow[0]),       32'h0);

        // Asynchronous reset in the middle of a strobe.
        do_write(0, 19'h001C0, 8'h99, 1'b1);
        wait_we_low(0, "rst_reach_strobe");
        rst_n = 1'b0;
        void'(q0.pop_back());
        #1;
        chk("rst_mid_we",  32'(ram_we_l[0]),    32'h1);
        chk("rst_mid_den", 32'(ram_dout_en[0]), 32'h0);
        chk("rst_mid_pix", 32'(pixel_data[0]),  32'h0);
        chk("rst_mid_ovf", 32'(wr_overflow[1]), 32'h0);
        isa_read[0] = 1'b1;
        isa_addr[0] = 19'h001C0;
        #1;
        chk("rst_fifo_empty", 32'(isa_dout[0]), 32'h03);
        isa_read[0] = 1'b0;
        #20;
        rst_n = 1'b1;
        repeat (4) step();
        chk("rst_no_write", 32'(rd(0, 19'h001C0)), 32'h03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
